ysyx_22050854_ifu: RTL and testbench

YSYX_22050854_IFU -- requirements
Module: ysyx_22050854_ifu

---
 rtl/ysyx_22050854_ifu.sv | 131 +++++++++++++
 tb/tb_ysyx_22050854_ifu.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_ifu.sv
// Instruction fetch unit: one outstanding imem transaction, decode-side hold register.
// Optional macro YSYX_22050854_IFU_MISALIGN_CHECK_EN faults unaligned PCs without a memory request.
module ysyx_22050854_ifu #(
    parameter logic [31:0] RESET_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        fetch_err_o,
    input  logic        inst_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        err_q, err_d;
    logic        accept;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        err_d      = err_q;
        pc_ready_o = 1'b0;
        accept     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                pc_ready_o = !flush_i;
                accept     = pc_valid_i && !flush_i;
            end
            S_REQ: begin
                if (flush_i)         state_d = imem_gnt_i ? S_DRAIN : S_IDLE;
                else if (imem_gnt_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) begin
                    state_d = imem_rvalid_i ? S_IDLE : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    inst_d    = imem_rdata_i;
                    err_d     = imem_err_i;
                    inst_pc_d = addr_q;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                // Flush wins over a consume in the same cycle.
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (inst_ready_i) begin
                    pc_ready_o = 1'b1;
                    accept     = pc_valid_i;
                    state_d    = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            addr_d  = pc_i;
            state_d = S_REQ;
`ifdef YSYX_22050854_IFU_MISALIGN_CHECK_EN
            if (pc_i[1:0] != 2'b00) begin
                inst_d    = RESET_INST;
                inst_pc_d = pc_i;
                err_d     = 1'b1;
                state_d   = S_HOLD;
            end
`endif
        end

        if (flush_i) begin
            inst_d = RESET_INST;
            err_d  = 1'b0;
        end

        // Reset state is IDLE, but the handshake must stay closed while reset is held.
        if (!rst) pc_ready_o = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            inst_q    <= RESET_INST;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= state_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    assign imem_req_o   = (state_q == S_REQ);
    assign imem_addr_o  = addr_q;
    assign inst_valid_o = (state_q == S_HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_ysyx_22050854_ifu.sv
// Self-checking bench for ysyx_22050854_ifu: fetch vector table with a scoreboard,
// plus directed flush / reset / alignment sequences.
module tb_ysyx_22050854_ifu;

    localparam logic [31:0] RESET_INST = 32'h00000013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        fetch_err_o;
    logic        inst_ready_i;

    ysyx_22050854_ifu #(.RESET_INST(RESET_INST)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .pc_ready_o   (pc_ready_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_err_i   (imem_err_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .fetch_err_o  (fetch_err_o),
        .inst_ready_i (inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rdata;
        logic        err;
        int          gnt_wait;
        int          rv_wait;
        int          rdy_wait;
        logic        chain;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];
    vec_t extra;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input vec_t v);
        sb.push_back('{v.rdata, v.pc, v.err});
    endtask

    // Present a PC in IDLE and let it be accepted; leaves the DUT in REQ.
    task automatic issue(input logic [31:0] pc);
        pc_i       = pc;
        pc_valid_i = 1'b1;
        @(negedge clk);
        check("issue_pc_ready", pc_ready_o, 1'b1);
        check("issue_no_req", imem_req_o, 1'b0);
        tick();
        pc_valid_i = 1'b0;
    endtask

    // Drive one transaction from REQ through consume; optionally chain the next PC.
    task automatic serve(input vec_t v, input vec_t nxt);
        for (int k = 0; k < v.gnt_wait; k++) begin
            imem_gnt_i = 1'b0;
            @(negedge clk);
            check("req_stable", imem_req_o, 1'b1);
            check("addr_stable", imem_addr_o, v.pc);
            check("req_pc_ready", pc_ready_o, 1'b0);
            tick();
        end
        imem_gnt_i = 1'b1;
        @(negedge clk);
        check("req_at_gnt", imem_req_o, 1'b1);
        check("addr_at_gnt", imem_addr_o, v.pc);
        tick();
        imem_gnt_i = 1'b0;
        for (int k = 0; k < v.rv_wait; k++) begin
            @(negedge clk);
            check("wait_single_txn", imem_req_o, 1'b0);
            check("wait_no_valid", inst_valid_o, 1'b0);
            check("wait_pc_ready", pc_ready_o, 1'b0);
            tick();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = v.rdata;
        imem_err_i    = v.err;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'hA5A5A5A5;
        imem_err_i    = 1'b0;
        for (int k = 0; k < v.rdy_wait; k++) begin
            @(negedge clk);
            check("hold_valid", inst_valid_o, 1'b1);
            check("hold_pc_ready", pc_ready_o, 1'b0);
            check("hold_inst", inst_o, v.rdata);
            check("hold_inst_pc", inst_pc_o, v.pc);
            tick();
        end
        inst_ready_i = 1'b1;
        if (v.chain) begin
            pc_i       = nxt.pc;
            pc_valid_i = 1'b1;
            push(nxt);
        end
        @(negedge clk);
        check("consume_valid", inst_valid_o, 1'b1);
        if (v.chain) check("b2b_pc_ready", pc_ready_o, 1'b1);
        tick();
        inst_ready_i = 1'b0;
        pc_valid_i   = 1'b0;
    endtask

    // Scoreboard: every consumed instruction must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst && inst_valid_o && inst_ready_i && !flush_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual=%h/%h expected=none t=%0t", inst_o, inst_pc_o, $time);
            end else begin
                mon_e = sb.pop_front();
                check("sb_inst", inst_o, mon_e.inst);
                check("sb_inst_pc", inst_pc_o, mon_e.pc);
                check("sb_err", fetch_err_o, mon_e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit chained;
        vecs[0] = '{32'h80000000, 32'h00100093, 1'b0, 0, 0, 0, 1'b0};
        vecs[1] = '{32'h80000004, 32'h00200113, 1'b0, 3, 0, 0, 1'b0};
        vecs[2] = '{32'h80000008, 32'h00308193, 1'b0, 0, 1, 5, 1'b1};
        vecs[3] = '{32'h8000000C, 32'h00400213, 1'b0, 0, 0, 0, 1'b1};
        vecs[4] = '{32'h80000010, 32'hFFFFFFFF, 1'b1, 1, 2, 1, 1'b0};
        vecs[5] = '{32'h00000100, 32'h12345678, 1'b0, 0, 0, 2, 1'b0};

        rst           = 1'b0;
        pc_i          = 32'h80000000;
        pc_valid_i    = 1'b1;
        flush_i       = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEADBEEF;
        imem_err_i    = 1'b1;
        inst_ready_i  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pc_ready", pc_ready_o, 1'b0);
        check("rst_req", imem_req_o, 1'b0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_valid", inst_valid_o, 1'b0);
        check("rst_inst", inst_o, RESET_INST);
        check("rst_inst_pc", inst_pc_o, 32'h0);
        check("rst_err", fetch_err_o, 1'b0);
        tick();
        pc_valid_i    = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_err_i    = 1'b0;
        inst_ready_i  = 1'b0;
        rst           = 1'b1;
        tick();

        chained = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (!chained) begin
                issue(vecs[i].pc);
                push(vecs[i]);
            end
            serve(vecs[i], vecs[(i < 5) ? i + 1 : i]);
            chained = vecs[i].chain;
        end

        // Flush in WAIT, late response must be drained and dropped.
        issue(32'h80000020);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        flush_i    = 1'b1;
        @(negedge clk);
        check("wflush_pc_ready", pc_ready_o, 1'b0);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("drain_req", imem_req_o, 1'b0);
        check("drain_pc_ready", pc_ready_o, 1'b0);
        check("drain_valid", inst_valid_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        check("drain_rv_pc_ready", pc_ready_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("drain_done_valid", inst_valid_o, 1'b0);
        check("drain_done_idle", pc_ready_o, 1'b1);
        check("drain_done_inst", inst_o, RESET_INST);
        tick();
        extra = '{32'h80000024, 32'h00500293, 1'b0, 0, 0, 0, 1'b0};
        issue(extra.pc);
        push(extra);
        serve(extra, extra);

        // Flush in REQ without grant, then a stray response in IDLE.
        issue(32'h80000030);
        flush_i = 1'b1;
        @(negedge clk);
        check("rflush_req_same", imem_req_o, 1'b1);
        tick();
        flush_i = 1'b0;
        @(negedge clk);
        check("rflush_req_drop", imem_req_o, 1'b0);
        check("rflush_idle", pc_ready_o, 1'b1);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0BADF00D;
        tick();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("stray_rv_valid", inst_valid_o, 1'b0);
        check("stray_rv_req", imem_req_o, 1'b0);
        tick();

        // Flush in REQ together with grant goes through DRAIN.
        issue(32'h80000040);
        flush_i    = 1'b1;
        imem_gnt_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        imem_gnt_i = 1'b0;
        @(negedge clk);
        check("gflush_drain_ready", pc_ready_o, 1'b0);
        check("gflush_drain_req", imem_req_o, 1'b0);
        tick();
        imem_rvalid_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("gflush_idle", pc_ready_o, 1'b1);
        check("gflush_valid", inst_valid_o, 1'b0);
        tick();

        // Flush in WAIT with the response in the same cycle.
        issue(32'h80000050);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'hCAFEF00D;
        flush_i       = 1'b1;
        tick();
        imem_rvalid_i = 1'b0;
        flush_i       = 1'b0;
        @(negedge clk);
        check("rvflush_valid", inst_valid_o, 1'b0);
        check("rvflush_idle", pc_ready_o, 1'b1);
        check("rvflush_inst", inst_o, RESET_INST);
        tick();

        // Flush in HOLD beats a simultaneous consume.
        issue(32'h80000060);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h00600313;
        tick();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("hflush_pre_valid", inst_valid_o, 1'b1);
        check("hflush_pre_inst", inst_o, 32'h00600313);
        tick();
        flush_i      = 1'b1;
        inst_ready_i = 1'b1;
        pc_valid_i   = 1'b1;
        pc_i         = 32'h80000064;
        @(negedge clk);
        check("hflush_pc_ready", pc_ready_o, 1'b0);
        tick();
        flush_i      = 1'b0;
        inst_ready_i = 1'b0;
        pc_valid_i   = 1'b0;
        @(negedge clk);
        check("hflush_valid", inst_valid_o, 1'b0);
        check("hflush_inst", inst_o, RESET_INST);
        check("hflush_no_req", imem_req_o, 1'b0);
        tick();

        // Reset in WAIT abandons the fetch; the late response is ignored.
        issue(32'h80000070);
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        check("mrst_req", imem_req_o, 1'b0);
        check("mrst_pc_ready", pc_ready_o, 1'b0);
        tick();
        rst           = 1'b1;
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = 32'h0BAD0BAD;
        tick();
        imem_rvalid_i = 1'b0;
        @(negedge clk);
        check("mrst_late_valid", inst_valid_o, 1'b0);
        check("mrst_late_inst", inst_o, RESET_INST);
        check("mrst_addr", imem_addr_o, 32'h0);
        tick();

        // Unaligned PC, with and without the alignment check compiled in.
`ifdef YSYX_22050854_IFU_MISALIGN_CHECK_EN
        issue(32'h80000002);
        sb.push_back('{RESET_INST, 32'h80000002, 1'b1});
        @(negedge clk);
        check("mis_no_req", imem_req_o, 1'b0);
        check("mis_valid", inst_valid_o, 1'b1);
        check("mis_err", fetch_err_o, 1'b1);
        tick();
        inst_ready_i = 1'b1;
        tick();
        inst_ready_i = 1'b0;
        @(negedge clk);
        check("mis_after_req", imem_req_o, 1'b0);
        tick();
`else
        extra = '{32'h80000002, 32'h00700393, 1'b0, 0, 0, 0, 1'b0};
        issue(extra.pc);
        push(extra);
        serve(extra, extra);
`endif

        repeat (2) tick();
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
